issue_queue: RTL and testbench
==============================

// Module: issue_queue
// PURPOSE
//  Age-ordered issue queue directly downstream of the map stage. Accepts renamed uops and
//  tracks readiness of physical source operands via busy-table reads plus writeback wakeup.
//  Presents the oldest fully-ready uop to execute. Backpressures map through `full`.
// PARAMETERS
//  IQ_DEPTH      8    number of entries (>=2); count width $clog2(IQ_DEPTH+1)
//  PHY_RF_DEPTH  128  physical register count; PHY_RF_ADDR_WIDTH=$clog2(PHY_RF_DEPTH)
// PORTS
//  clk               in   1      clock, rising edge
//  rst               in   1      reset, asynchronous, active-low (rst==0 resets)
//  flush             in   1      synchronous clear of all entries
//  uop_in            in   uop_t  renamed uop from map
//  uop_in_valid      in   1      uop_in valid this cycle
//  full              out  1      queue cannot accept; map must hold uop_in
//  busy_rd_addr1     out  PAW    busy-table read addr = uop_in.uop_ic.rs1
//  busy_rd_addr2     out  PAW    busy-table read addr = uop_in.uop_ic.rs2
//  busy_rd_data1     in   1      busy bit for addr1 (comb, same cycle)
//  busy_rd_data2     in   1      busy bit for addr2
//  wb_valid          in   1      writeback broadcast valid
//  wb_addr           in   PAW    physical reg being written back (becomes ready)
//  uop_out           out  uop_t  selected uop (entry contents, unmodified)
//  uop_out_valid     out  1      a ready entry exists
//  issue_ready       in   1      execute accepts uop_out this cycle
// BEHAVIOUR
//  Storage: IQ_DEPTH slots {uop, rs1_rdy, rs2_rdy}; slot 0 oldest; slots [0,count) valid.
//  Reset (rst low, async): count=0, all ready bits 0; outputs: full=0, uop_out_valid=0,
//    uop_out='0. rst low mid-operation drops all entries immediately; no issue that cycle.
//  enq = uop_in_valid & ~full; full = (count==IQ_DEPTH), from registered count only (an
//    issue in the same cycle does not free room for enqueue).
//  Enqueue ready bits: rsN_rdy = ~rsN_valid | ~busy_rd_dataN | (wb_valid & wb_addr==rsN).
//  Wakeup: at each edge with wb_valid, every valid entry with rsN_valid & rsN==wb_addr
//    sets rsN_rdy. Entry ready = rs1_rdy & rs2_rdy.
//  Select (comb): lowest-index ready slot; uop_out_valid = any ready; uop_out = that slot,
//    else '0. fire = uop_out_valid & issue_ready.
//  Issue: on fire, selected slot removed at edge; slots above shift down one (age kept).
//  Simultaneous enq+fire: shift first, new uop written to slot count-1; count unchanged.
//  count' = count + enq - fire; never exceeds IQ_DEPTH, never underflows.
//  Latency: enqueue at edge t -> earliest uop_out_valid in cycle t+1. Wakeup at edge t ->
//    dependent entry eligible in cycle t+1. No same-cycle enqueue->issue bypass.
//  uop_out_valid & ~issue_ready: nothing removed; selection re-evaluated next cycle (an
//    older entry newly woken may replace the presented uop; execute must not latch early).
//  flush: at edge, count=0, enq and fire ignored; wins over all other updates.
//  Ops without destination still occupy an entry; readiness only uses rs1/rs2 fields.
// TESTING
//  1 reset, no stim -> full=0, uop_out_valid=0; enqueue uop rs1/rs2 not busy -> valid next cycle.
//  2 enqueue A(rs1=p5 busy), B(no srcs), issue_ready=1 -> B issues first; wb p5 -> A next cycle.
//  3 fill 8 entries, all busy, issue_ready=0 -> full=1 after 8th; 9th uop_in held, not written.
//  4 full queue, enq+fire same cycle -> enq refused (full); count 8->7; next cycle accept.
//  5 wb_valid=1,wb_addr=p9 same cycle as enqueue rs2=p9 busy -> entry ready next cycle.
//  6 3 entries, flush=1 with uop_in_valid=1 -> count 0, uop_out_valid=0; rst low mid-burst -> empty.

Source files
------------

// File: rtl/issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : issue_queue
// Brief    : Age-ordered issue queue with busy-table readiness capture,
//            writeback wakeup and oldest-ready select.
// Revision : 1.0 - initial release
// ============================================================================
// uop layout (LSB first): rs1, rs1_valid, rs2, rs2_valid, payload.
module issue_queue #(
    parameter int IQ_DEPTH          = 8,
    parameter int PHY_RF_DEPTH      = 128,
    parameter int PHY_RF_ADDR_WIDTH = $clog2(PHY_RF_DEPTH),
    parameter int UOP_PAYLOAD_WIDTH = 16,
    parameter int UOP_WIDTH         = 2*PHY_RF_ADDR_WIDTH + 2 + UOP_PAYLOAD_WIDTH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush,
    input  logic [UOP_WIDTH-1:0]         uop_in,
    input  logic                         uop_in_valid,
    output logic                         full,
    output logic [PHY_RF_ADDR_WIDTH-1:0] busy_rd_addr1,
    output logic [PHY_RF_ADDR_WIDTH-1:0] busy_rd_addr2,
    input  logic                         busy_rd_data1,
    input  logic                         busy_rd_data2,
    input  logic                         wb_valid,
    input  logic [PHY_RF_ADDR_WIDTH-1:0] wb_addr,
    output logic [UOP_WIDTH-1:0]         uop_out,
    output logic                         uop_out_valid,
    input  logic                         issue_ready
);

    localparam int c_CW      = $clog2(IQ_DEPTH + 1);
    localparam int c_IW      = $clog2(IQ_DEPTH);
    localparam int c_PAW     = PHY_RF_ADDR_WIDTH;
    localparam int c_RS1_LSB = 0;
    localparam int c_RS1V    = c_PAW;
    localparam int c_RS2_LSB = c_PAW + 1;
    localparam int c_RS2V    = 2*c_PAW + 1;

    logic [UOP_WIDTH-1:0] r_uop [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]  r_rdy1;
    logic [IQ_DEPTH-1:0]  r_rdy2;
    logic [c_CW-1:0]      r_count;

    logic [IQ_DEPTH-1:0]  w_wake1;
    logic [IQ_DEPTH-1:0]  w_wake2;
    logic [IQ_DEPTH-1:0]  w_slot_valid;
    logic [IQ_DEPTH-1:0]  w_ready;
    logic [c_IW-1:0]      w_sel;
    logic                 w_any;
    logic                 w_enq;
    logic                 w_fire;
    logic                 w_enq_rdy1;
    logic                 w_enq_rdy2;
    logic [c_CW-1:0]      w_enq_slot;
    logic [UOP_WIDTH-1:0] w_nxt_uop [IQ_DEPTH];
    logic [IQ_DEPTH-1:0]  w_nxt_rdy1;
    logic [IQ_DEPTH-1:0]  w_nxt_rdy2;

    generate
        for (genvar i = 0; i < IQ_DEPTH; i++) begin : g_slot
            assign w_wake1[i] = wb_valid & r_uop[i][c_RS1V] &
                                (r_uop[i][c_RS1_LSB +: c_PAW] == wb_addr);
            assign w_wake2[i] = wb_valid & r_uop[i][c_RS2V] &
                                (r_uop[i][c_RS2_LSB +: c_PAW] == wb_addr);
            assign w_slot_valid[i] = (c_CW'(i) < r_count);
        end
    endgenerate

    // Selection uses registered ready bits only: wakeup takes effect next cycle.
    assign w_ready = w_slot_valid & r_rdy1 & r_rdy2;

    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = IQ_DEPTH - 1; i >= 0; i--) begin
            if (w_ready[i]) begin
                w_sel = c_IW'(i);
                w_any = 1'b1;
            end
        end
    end

    assign uop_out       = w_any ? r_uop[w_sel] : '0;
    assign uop_out_valid = w_any;
    assign full          = (r_count == c_CW'(IQ_DEPTH));
    assign busy_rd_addr1 = uop_in[c_RS1_LSB +: c_PAW];
    assign busy_rd_addr2 = uop_in[c_RS2_LSB +: c_PAW];

    assign w_enq      = uop_in_valid & ~full;
    assign w_fire     = w_any & issue_ready;
    assign w_enq_slot = r_count - c_CW'(w_fire);
    assign w_enq_rdy1 = ~uop_in[c_RS1V] | ~busy_rd_data1 |
                        (wb_valid & (wb_addr == busy_rd_addr1));
    assign w_enq_rdy2 = ~uop_in[c_RS2V] | ~busy_rd_data2 |
                        (wb_valid & (wb_addr == busy_rd_addr2));

    // Wakeup, then compaction above the issued slot, then enqueue at the new tail.
    always_comb begin
        for (int i = 0; i < IQ_DEPTH; i++) begin
            w_nxt_uop[i]  = r_uop[i];
            w_nxt_rdy1[i] = r_rdy1[i] | w_wake1[i];
            w_nxt_rdy2[i] = r_rdy2[i] | w_wake2[i];
        end
        for (int i = 0; i < IQ_DEPTH - 1; i++) begin
            if (w_fire && (c_IW'(i) >= w_sel)) begin
                w_nxt_uop[i]  = r_uop[i+1];
                w_nxt_rdy1[i] = r_rdy1[i+1] | w_wake1[i+1];
                w_nxt_rdy2[i] = r_rdy2[i+1] | w_wake2[i+1];
            end
        end
        if (w_fire) begin
            w_nxt_uop[IQ_DEPTH-1]  = '0;
            w_nxt_rdy1[IQ_DEPTH-1] = 1'b0;
            w_nxt_rdy2[IQ_DEPTH-1] = 1'b0;
        end
        for (int i = 0; i < IQ_DEPTH; i++) begin
            if (w_enq && (c_CW'(i) == w_enq_slot)) begin
                w_nxt_uop[i]  = uop_in;
                w_nxt_rdy1[i] = w_enq_rdy1;
                w_nxt_rdy2[i] = w_enq_rdy2;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_uop[i] <= '0;
            end
        end else if (flush) begin
            r_count <= '0;
            r_rdy1  <= '0;
            r_rdy2  <= '0;
        end else begin
            r_count <= r_count + c_CW'(w_enq) - c_CW'(w_fire);
            r_rdy1  <= w_nxt_rdy1;
            r_rdy2  <= w_nxt_rdy2;
            for (int i = 0; i < IQ_DEPTH; i++) begin
                r_uop[i] <= w_nxt_uop[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_issue_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_issue_queue
// Brief    : Directed bench for issue_queue against a queue-based reference.
// Revision : 1.0 - initial release
// ============================================================================
module tb_issue_queue;

    localparam int DEPTH = 8;
    localparam int PAW   = 7;
    localparam int UW    = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic           flush;
    logic [UW-1:0]  uop_in;
    logic           uop_in_valid;
    logic           full;
    logic [PAW-1:0] busy_rd_addr1;
    logic [PAW-1:0] busy_rd_addr2;
    logic           busy_rd_data1;
    logic           busy_rd_data2;
    logic           wb_valid;
    logic [PAW-1:0] wb_addr;
    logic [UW-1:0]  uop_out;
    logic           uop_out_valid;
    logic           issue_ready;

    bit [127:0] busy_tab;
    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        logic [31:0] uop;
        bit          r1;
        bit          r2;
    } ent_t;
    ent_t mq[$];

    assign busy_rd_data1 = busy_tab[busy_rd_addr1];
    assign busy_rd_data2 = busy_tab[busy_rd_addr2];

    always #5 clk = ~clk;

    issue_queue #(
        .IQ_DEPTH     (DEPTH),
        .PHY_RF_DEPTH (128)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .uop_in        (uop_in),
        .uop_in_valid  (uop_in_valid),
        .full          (full),
        .busy_rd_addr1 (busy_rd_addr1),
        .busy_rd_addr2 (busy_rd_addr2),
        .busy_rd_data1 (busy_rd_data1),
        .busy_rd_data2 (busy_rd_data2),
        .wb_valid      (wb_valid),
        .wb_addr       (wb_addr),
        .uop_out       (uop_out),
        .uop_out_valid (uop_out_valid),
        .issue_ready   (issue_ready)
    );

    function automatic logic [31:0] mk(int tag, bit v1, int r1, bit v2, int r2);
        return {tag[15:0], v2, r2[6:0], v1, r1[6:0]};
    endfunction

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic idle();
        uop_in_valid = 1'b0;
        issue_ready  = 1'b0;
        wb_valid     = 1'b0;
        wb_addr      = '0;
        flush        = 1'b0;
        uop_in       = '0;
    endtask

    // One clock: compare DUT against the reference, then advance the reference.
    task automatic tick();
        int   sel;
        bit   enq;
        bit   fire;
        ent_t e;
        #1;
        sel = -1;
        for (int i = 0; i < mq.size(); i++) begin
            if (mq[i].r1 && mq[i].r2) begin
                sel = i;
                break;
            end
        end
        chk("full", {31'd0, full}, {31'd0, mq.size() == DEPTH});
        chk("uop_out_valid", {31'd0, uop_out_valid}, {31'd0, sel >= 0});
        chk("uop_out", uop_out, (sel >= 0) ? mq[sel].uop : 32'd0);
        chk("busy_rd_addr1", {25'd0, busy_rd_addr1}, {25'd0, uop_in[6:0]});
        chk("busy_rd_addr2", {25'd0, busy_rd_addr2}, {25'd0, uop_in[14:8]});
        enq  = uop_in_valid && (mq.size() < DEPTH);
        fire = (sel >= 0) && issue_ready;
        e.uop = uop_in;
        e.r1  = !uop_in[7]  || !busy_tab[uop_in[6:0]]  || (wb_valid && wb_addr == uop_in[6:0]);
        e.r2  = !uop_in[15] || !busy_tab[uop_in[14:8]] || (wb_valid && wb_addr == uop_in[14:8]);
        if (!rst || flush) begin
            mq.delete();
        end else begin
            for (int i = 0; i < mq.size(); i++) begin
                if (wb_valid && mq[i].uop[7]  && mq[i].uop[6:0]  == wb_addr) mq[i].r1 = 1'b1;
                if (wb_valid && mq[i].uop[15] && mq[i].uop[14:8] == wb_addr) mq[i].r2 = 1'b1;
            end
            if (fire) mq.delete(sel);
            if (enq)  mq.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        busy_tab = '0;
        rst = 1'b0;
        idle();
        #1;
        chk("reset_full", {31'd0, full}, 32'd0);
        chk("reset_valid", {31'd0, uop_out_valid}, 32'd0);
        chk("reset_uop_out", uop_out, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Ready uop appears the cycle after enqueue.
        tick();
        uop_in = mk(1, 1, 1, 1, 2); uop_in_valid = 1'b1;
        tick();
        uop_in_valid = 1'b0;
        chk("t1_valid", {31'd0, uop_out_valid}, 32'd1);
        chk("t1_uop", uop_out, mk(1, 1, 1, 1, 2));
        issue_ready = 1'b1;
        tick();
        idle();
        chk("t1_drained", {31'd0, uop_out_valid}, 32'd0);

        // Younger ready uop bypasses an older waiting one; wakeup releases the older.
        busy_tab[5] = 1'b1;
        uop_in = mk(2, 1, 5, 0, 0); uop_in_valid = 1'b1;
        tick();
        uop_in = mk(3, 0, 0, 0, 0);
        tick();
        uop_in_valid = 1'b0;
        chk("t2_b_first", uop_out, mk(3, 0, 0, 0, 0));
        issue_ready = 1'b1;
        tick();
        chk("t2_a_waits", {31'd0, uop_out_valid}, 32'd0);
        wb_valid = 1'b1; wb_addr = 7'd5; busy_tab[5] = 1'b0;
        tick();
        wb_valid = 1'b0;
        chk("t2_a_woken", uop_out, mk(2, 1, 5, 0, 0));
        tick();
        idle();
        chk("t2_empty", {31'd0, uop_out_valid}, 32'd0);

        // Fill to capacity with waiting uops; extra uop is held off.
        for (int k = 0; k < DEPTH; k++) begin
            busy_tab[20+k] = 1'b1;
            uop_in = mk(16 + k, 1, 20 + k, 0, 0); uop_in_valid = 1'b1;
            tick();
        end
        chk("t3_full", {31'd0, full}, 32'd1);
        uop_in = mk(99, 0, 0, 0, 0);
        tick();
        tick();
        chk("t3_still_full", {31'd0, full}, 32'd1);
        chk("t3_not_written", {31'd0, uop_out_valid}, 32'd0);

        // Issue from a full queue does not make room for enqueue in the same cycle.
        wb_valid = 1'b1; wb_addr = 7'd23; busy_tab[23] = 1'b0;
        tick();
        wb_valid = 1'b0;
        chk("t4_sel_mid", uop_out, mk(19, 1, 23, 0, 0));
        issue_ready = 1'b1;
        tick();
        issue_ready = 1'b0;
        chk("t4_count7", {31'd0, full}, 32'd0);
        chk("t4_refused", {31'd0, uop_out_valid}, 32'd0);
        tick();
        uop_in_valid = 1'b0;
        chk("t4_refull", {31'd0, full}, 32'd1);
        chk("t4_tail", uop_out, mk(99, 0, 0, 0, 0));
        issue_ready = 1'b1;
        for (int k = 0; k < DEPTH; k++) begin
            wb_valid = (k != 3); wb_addr = 7'(20 + k); busy_tab[20+k] = 1'b0;
            tick();
        end
        wb_valid = 1'b0;
        repeat (10) tick();
        idle();
        chk("t4_drained", {31'd0, uop_out_valid}, 32'd0);

        // Older entry woken while a younger one is presented takes over selection.
        busy_tab[40] = 1'b1;
        uop_in = mk(41, 1, 40, 0, 0); uop_in_valid = 1'b1;
        tick();
        uop_in = mk(42, 0, 0, 0, 0);
        tick();
        uop_in_valid = 1'b0;
        chk("t7_young", uop_out, mk(42, 0, 0, 0, 0));
        wb_valid = 1'b1; wb_addr = 7'd40; busy_tab[40] = 1'b0;
        tick();
        wb_valid = 1'b0;
        chk("t7_old_wins", uop_out, mk(41, 1, 40, 0, 0));
        issue_ready = 1'b1;
        tick();
        tick();
        idle();

        // Writeback in the enqueue cycle counts as ready.
        busy_tab[9] = 1'b1;
        uop_in = mk(5, 0, 0, 1, 9); uop_in_valid = 1'b1;
        wb_valid = 1'b1; wb_addr = 7'd9;
        tick();
        idle();
        chk("t5_ready", uop_out, mk(5, 0, 0, 1, 9));
        busy_tab[9] = 1'b0;
        issue_ready = 1'b1;
        tick();
        idle();

        // Flush beats a concurrent enqueue.
        busy_tab[30] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            uop_in = mk(60 + k, 1, 30, 0, 0); uop_in_valid = 1'b1;
            tick();
        end
        flush = 1'b1;
        uop_in = mk(77, 0, 0, 0, 0);
        tick();
        idle();
        chk("t6_flush_valid", {31'd0, uop_out_valid}, 32'd0);
        tick();
        chk("t6_flush_empty", {31'd0, uop_out_valid}, 32'd0);

        // Asynchronous reset in the middle of an enqueue burst.
        for (int k = 0; k < 3; k++) begin
            uop_in = mk(80 + k, 0, 0, 0, 0); uop_in_valid = 1'b1;
            tick();
        end
        chk("t6_pre_rst", uop_out, mk(80, 0, 0, 0, 0));
        #2;
        rst = 1'b0;
        #1;
        chk("t6_async_rst", {31'd0, uop_out_valid}, 32'd0);
        mq.delete();
        tick();
        rst = 1'b1;
        idle();
        tick();
        chk("t6_post_rst", {31'd0, uop_out_valid}, 32'd0);
        uop_in = mk(90, 0, 0, 0, 0); uop_in_valid = 1'b1;
        tick();
        idle();
        chk("t6_restart", uop_out, mk(90, 0, 0, 0, 0));
        issue_ready = 1'b1;
        tick();
        idle();
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
